mips_multicycle_controller: RTL and testbench
=============================================

Name: mips_multicycle_controller

Overview:
- Moore FSM that sequences a multi-cycle MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut registers, single ALU.
- Replaces the single-cycle combinational control path for the multi-cycle core.
- Decodes opcode/funct internally to ALUControl.
- Stalls on a memory ready handshake and flags unsupported opcodes.

Parameters:
- MEM_WAIT_MAX, 16, maximum cycles waiting on mem_ready before mem_timeout pulses and the FSM returns to FETCH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- funct  input  6  IR[5:0]
- Zero_flag  input  1  ALU zero result
- mem_ready  input  1  memory access completes this cycle
- mem_req  output  1  memory access request
- IorD  output  1  0 = PC address, 1 = ALUOut address
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  load IR
- PCEn  output  1  PC load enable
- PCSrc  output  2  00 ALU, 01 ALUOut, 10 jump target
- RegDst  output  1  1 = rd, 0 = rt
- MemToReg  output  1  1 = data register, 0 = ALUOut
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 = PC, 1 = A
- ALUSrcB  output  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
- ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal_op  output  1  one-cycle pulse, unsupported opcode/funct
- mem_timeout  output  1  one-cycle pulse, wait limit hit
- state  output  4  current state, debug

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12.
- rst_n low at a clk edge: state <= IDLE, wait counter <= 0.
- IDLE: all outputs 0 (ALUControl 000, PCSrc 00, ALUSrcB 00). Unconditionally goes to FETCH the next cycle.
- Outputs are combinational from state, plus mem_ready/Zero_flag where noted. Unlisted outputs are 0 in every state.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00.
  - IRWrite=PCEn=mem_ready.
  - mem_ready=1 -> DECODE; else stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH, illegal_op=1 this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010. lw -> MEMRD; sw -> MEMWR.
- MEMRD: mem_req=1, IorD=1. mem_ready -> MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemToReg=1. -> FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=mem_ready. mem_ready -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl from funct:
  - 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
  - any other funct -> 010, illegal_op=1, next state FETCH (no ALUWB)
  - valid funct -> ALUWB
- ALUWB: RegWrite=1, RegDst=1, MemToReg=0. -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, PCEn=Zero_flag. -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010. -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemToReg=0. -> FETCH.
- JUMP: PCSrc=10, PCEn=1. -> FETCH.
- Wait counter (FETCH, MEMRD, MEMWR only):
  - Increments each cycle mem_req=1 and mem_ready=0; clears on state change.
  - When it equals MEM_WAIT_MAX-1 and mem_ready=0: mem_timeout=1, all write enables stay 0, next state FETCH, counter cleared.
  - mem_ready=1 on that same cycle takes priority; no timeout.
- States not listed above (13-15) -> FETCH, illegal_op=1.
- Reset mid-instruction: write enables drop to 0 in the cycle after the reset edge (IDLE); no partial writeback.
- Cycle counts with mem_ready always 1, counted from FETCH entry: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Test Plan:
- Reset then lw (opcode 100011), mem_ready=1 -> state 0,1,2,3,4,5,1. RegWrite=1 only in MEMWB with MemToReg=1, RegDst=0.
- R-type sub (funct 100010) -> EXEC ALUControl=110, ALUWB RegWrite=1 RegDst=1. funct 000111 -> illegal_op pulse, no RegWrite, back to FETCH.
- beq with Zero_flag=1 -> PCEn=1, PCSrc=01 in BRANCH. With Zero_flag=0 -> PCEn=0. Both return to FETCH after 3 cycles.
- sw with mem_ready low 3 cycles in MEMWR -> MemWrite=0 for 3 cycles, then one MemWrite=1 cycle, then FETCH.
- MEM_WAIT_MAX=4, mem_ready held 0 in FETCH -> mem_timeout pulses on the 4th cycle, IRWrite never asserted, FETCH re-entered with counter 0.
- rst_n low during MEMWB -> next cycle state=0 and RegWrite=0; opcode 111111 in DECODE -> illegal_op=1 for exactly 1 cycle.

Source files
------------

// File: rtl/mips_multicycle_controller_if.sv
// Control/status bundle between the multi-cycle MIPS controller and its datapath.
// The master side is the controller: it reads the decoded instruction fields and
// datapath flags, and drives every datapath control strobe.
interface mips_multicycle_controller_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       Zero_flag;
   logic       mem_ready;
   logic       mem_req;
   logic       IorD;
   logic       MemWrite;
   logic       IRWrite;
   logic       PCEn;
   logic [1:0] PCSrc;
   logic       RegDst;
   logic       MemToReg;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic       illegal_op;
   logic       mem_timeout;
   logic [3:0] state;

   modport master (
      input  opcode, funct, Zero_flag, mem_ready,
      output mem_req, IorD, MemWrite, IRWrite, PCEn, PCSrc, RegDst, MemToReg,
             RegWrite, ALUSrcA, ALUSrcB, ALUControl, illegal_op, mem_timeout, state
   );

   modport slave (
      output opcode, funct, Zero_flag, mem_ready,
      input  mem_req, IorD, MemWrite, IRWrite, PCEn, PCSrc, RegDst, MemToReg,
             RegWrite, ALUSrcA, ALUSrcB, ALUControl, illegal_op, mem_timeout, state
   );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Moore controller for a multi-cycle MIPS datapath (shared memory, IR, A/B/ALUOut).
// Outputs are decoded from the current state, qualified by mem_ready / Zero_flag
// where a strobe must only fire on a completed access or a taken branch.
// Memory-facing states carry a bounded wait counter; on expiry the access is
// abandoned with a mem_timeout pulse and the FSM restarts at FETCH.
module mips_multicycle_controller #(
   parameter int MEM_WAIT_MAX = 16
) (
   input logic                          clk,
   input logic                          rst_n,
   mips_multicycle_controller_if.master bus
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD  = 4'd4;
   localparam logic [3:0] S_MEMWB  = 4'd5;
   localparam logic [3:0] S_MEMWR  = 4'd6;
   localparam logic [3:0] S_EXEC   = 4'd7;
   localparam logic [3:0] S_ALUWB  = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_ADDIEX = 4'd10;
   localparam logic [3:0] S_ADDIWB = 4'd11;
   localparam logic [3:0] S_JUMP   = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // Counter wide enough to hold MEM_WAIT_MAX-1 for any legal parameter value.
   localparam int          CW       = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CW-1:0] WAIT_LIM = CW'(MEM_WAIT_MAX - 1);

   logic [3:0]    r_state;
   logic [CW-1:0] r_wait_cnt;
   logic [3:0]    w_next_state;
   logic [CW-1:0] w_cnt_next;
   logic          w_waiting;
   logic          w_timeout;

   // R-type funct to ALU operation; unsupported functs fall back to add.
   function automatic logic [2:0] alu_from_funct(input logic [5:0] f);
      case (f)
         6'b100000: alu_from_funct = 3'b010;
         6'b100010: alu_from_funct = 3'b110;
         6'b100100: alu_from_funct = 3'b000;
         6'b100101: alu_from_funct = 3'b001;
         6'b101010: alu_from_funct = 3'b111;
         default:   alu_from_funct = 3'b010;
      endcase
   endfunction

   function automatic logic funct_legal(input logic [5:0] f);
      case (f)
         6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
         default: funct_legal = 1'b0;
      endcase
   endfunction

   // Only the memory-access states may stall; the timeout fires on the last allowed idle cycle.
   assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
   assign w_timeout = w_waiting && !bus.mem_ready && (r_wait_cnt == WAIT_LIM);

   // State and wait-counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= {CW{1'b0}};
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_cnt_next;
      end
   end

   // Next-state selection and wait-counter update.
   always_comb begin
      w_next_state = S_FETCH;
      w_cnt_next   = {CW{1'b0}};
      if (w_waiting && !bus.mem_ready && !w_timeout) begin
         w_cnt_next = r_wait_cnt + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         w_cnt_next = {CW{1'b0}};
      end
      case (r_state)
         S_IDLE:   w_next_state = S_FETCH;
         S_FETCH:  w_next_state = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: w_next_state = S_MEMADR;
               OP_RTYPE:     w_next_state = S_EXEC;
               OP_BEQ:       w_next_state = S_BRANCH;
               OP_ADDI:      w_next_state = S_ADDIEX;
               OP_J:         w_next_state = S_JUMP;
               default:      w_next_state = S_FETCH;
            endcase
         end
         S_MEMADR: w_next_state = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (bus.mem_ready)   w_next_state = S_MEMWB;
            else if (w_timeout)  w_next_state = S_FETCH;
            else                 w_next_state = S_MEMRD;
         end
         S_MEMWB:  w_next_state = S_FETCH;
         S_MEMWR: begin
            if (bus.mem_ready)   w_next_state = S_FETCH;
            else if (w_timeout)  w_next_state = S_FETCH;
            else                 w_next_state = S_MEMWR;
         end
         S_EXEC:   w_next_state = funct_legal(bus.funct) ? S_ALUWB : S_FETCH;
         S_ALUWB:  w_next_state = S_FETCH;
         S_BRANCH: w_next_state = S_FETCH;
         S_ADDIEX: w_next_state = S_ADDIWB;
         S_ADDIWB: w_next_state = S_FETCH;
         S_JUMP:   w_next_state = S_FETCH;
         default:  w_next_state = S_FETCH;
      endcase
   end

   // Datapath control decode from the current state.
   always_comb begin
      bus.mem_req     = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.PCEn        = 1'b0;
      bus.PCSrc       = 2'b00;
      bus.RegDst      = 1'b0;
      bus.MemToReg    = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = 2'b00;
      bus.ALUControl  = 3'b000;
      bus.illegal_op  = 1'b0;
      bus.mem_timeout = w_timeout;
      bus.state       = r_state;
      case (r_state)
         S_IDLE: begin
            bus.mem_timeout = 1'b0;
         end
         S_FETCH: begin
            bus.mem_req    = 1'b1;
            bus.ALUSrcB    = 2'b01;
            bus.ALUControl = 3'b010;
            bus.IRWrite    = bus.mem_ready;
            bus.PCEn       = bus.mem_ready;
         end
         S_DECODE: begin
            bus.ALUSrcB    = 2'b11;
            bus.ALUControl = 3'b010;
            case (bus.opcode)
               OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: bus.illegal_op = 1'b0;
               default:                                       bus.illegal_op = 1'b1;
            endcase
         end
         S_MEMADR, S_ADDIEX: begin
            bus.ALUSrcA    = 1'b1;
            bus.ALUSrcB    = 2'b10;
            bus.ALUControl = 3'b010;
         end
         S_MEMRD: begin
            bus.mem_req = 1'b1;
            bus.IorD    = 1'b1;
         end
         S_MEMWB: begin
            bus.RegWrite = 1'b1;
            bus.MemToReg = 1'b1;
         end
         S_MEMWR: begin
            bus.mem_req  = 1'b1;
            bus.IorD     = 1'b1;
            bus.MemWrite = bus.mem_ready;
         end
         S_EXEC: begin
            bus.ALUSrcA    = 1'b1;
            bus.ALUControl = alu_from_funct(bus.funct);
            bus.illegal_op = !funct_legal(bus.funct);
         end
         S_ALUWB: begin
            bus.RegWrite = 1'b1;
            bus.RegDst   = 1'b1;
         end
         S_BRANCH: begin
            bus.ALUSrcA    = 1'b1;
            bus.ALUControl = 3'b110;
            bus.PCSrc      = 2'b01;
            bus.PCEn       = bus.Zero_flag;
         end
         S_ADDIWB: begin
            bus.RegWrite = 1'b1;
         end
         S_JUMP: begin
            bus.PCSrc = 2'b10;
            bus.PCEn  = 1'b1;
         end
         default: begin
            bus.illegal_op = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Scoreboard bench for the multi-cycle MIPS controller. Each instruction is
// expanded from a per-opcode recipe into the cycle-by-cycle control vector the
// datapath should see; a monitor compares every cycle on the falling edge.
module tb_mips_multicycle_controller;

   localparam int TB_MAX = 4;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_req;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       pcen;
      logic [1:0] pcsrc;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] aluctl;
      logic       illegal;
      logic       timeout;
   } ctl_t;

   logic clk;
   logic rst_n;
   ctl_t sb[$];
   ctl_t act;
   int   checks = 0;
   int   errors = 0;
   int   cyc_no = 0;

   mips_multicycle_controller_if bus ();

   mips_multicycle_controller #(.MEM_WAIT_MAX(TB_MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      act          = '0;
      act.st       = bus.state;
      act.mem_req  = bus.mem_req;
      act.iord     = bus.IorD;
      act.memwrite = bus.MemWrite;
      act.irwrite  = bus.IRWrite;
      act.pcen     = bus.PCEn;
      act.pcsrc    = bus.PCSrc;
      act.regdst   = bus.RegDst;
      act.memtoreg = bus.MemToReg;
      act.regwrite = bus.RegWrite;
      act.alusrca  = bus.ALUSrcA;
      act.alusrcb  = bus.ALUSrcB;
      act.aluctl   = bus.ALUControl;
      act.illegal  = bus.illegal_op;
      act.timeout  = bus.mem_timeout;
   end

   // Monitor: one expected control vector per cycle, compared mid-cycle.
   always @(negedge clk) begin
      ctl_t e;
      cyc_no++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL ctl cycle %0d: got state=%0d vec=%h, expected state=%0d vec=%h",
                     cyc_no, act.st, act, e.st, e);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   function automatic ctl_t mk(input logic [3:0] st);
      ctl_t e;
      e    = '0;
      e.st = st;
      return e;
   endfunction

   function automatic logic funct_ok(input logic [5:0] f);
      return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
             (f == 6'b100101) || (f == 6'b101010);
   endfunction

   function automatic logic [2:0] exp_alu(input logic [5:0] f);
      logic [2:0] r;
      case (f)
         6'b100010: r = 3'b110;
         6'b100100: r = 3'b000;
         6'b100101: r = 3'b001;
         6'b101010: r = 3'b111;
         default:   r = 3'b010;
      endcase
      return r;
   endfunction

   function automatic logic op_ok(input logic [5:0] op);
      return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
             (op == OP_ADDI) || (op == OP_J);
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Apply one cycle of inputs and record what the controller must show during it.
   task automatic drive(input ctl_t e, input logic mr, input logic zf, input logic rn);
      bus.mem_ready = mr;
      bus.Zero_flag = zf;
      rst_n         = rn;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // A memory access that completes after k idle cycles, or times out when k >= TB_MAX.
   task automatic mem_phase(input logic [3:0] st, input int k_in, output logic ok);
      int   k;
      int   r;
      ctl_t e;
      logic done;
      k = k_in;
      if (k < 0) begin
         r = int'($urandom_range(0, 9));
         if (r < 5)      k = 0;
         else if (r < 9) k = int'($urandom_range(1, TB_MAX - 1));
         else            k = TB_MAX;
      end
      ok   = 1'b0;
      done = 1'b0;
      for (int i = 0; i < TB_MAX; i++) begin
         if (!done) begin
            e         = mk(st);
            e.mem_req = 1'b1;
            if (st == 4'd1) begin
               e.alusrcb = 2'b01;
               e.aluctl  = 3'b010;
            end else begin
               e.iord = 1'b1;
            end
            if (i == k) begin
               if (st == 4'd1) begin
                  e.irwrite = 1'b1;
                  e.pcen    = 1'b1;
               end
               if (st == 4'd6) e.memwrite = 1'b1;
               drive(e, 1'b1, rbit(), 1'b1);
               ok   = 1'b1;
               done = 1'b1;
            end else begin
               if (i == TB_MAX - 1) e.timeout = 1'b1;
               drive(e, 1'b0, rbit(), 1'b1);
            end
         end
      end
   endtask

   // Expand one instruction into its expected cycle sequence, starting at FETCH.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int kf,
                            input int km, input int zsel, input logic rst_wb);
      logic ok;
      logic zf;
      ctl_t e;
      bus.opcode = op;
      bus.funct  = fn;
      mem_phase(4'd1, kf, ok);
      while (!ok) mem_phase(4'd1, int'($urandom_range(0, TB_MAX - 1)), ok);
      e         = mk(4'd2);
      e.alusrcb = 2'b11;
      e.aluctl  = 3'b010;
      e.illegal = !op_ok(op);
      drive(e, rbit(), rbit(), 1'b1);
      if (op == OP_LW || op == OP_SW) begin
         e         = mk(4'd3);
         e.alusrca = 1'b1;
         e.alusrcb = 2'b10;
         e.aluctl  = 3'b010;
         drive(e, rbit(), rbit(), 1'b1);
         mem_phase((op == OP_LW) ? 4'd4 : 4'd6, km, ok);
         if (ok && op == OP_LW) begin
            e          = mk(4'd5);
            e.regwrite = 1'b1;
            e.memtoreg = 1'b1;
            drive(e, rbit(), rbit(), !rst_wb);
            if (rst_wb) drive(mk(4'd0), rbit(), rbit(), 1'b1);
         end
      end else if (op == OP_R) begin
         e         = mk(4'd7);
         e.alusrca = 1'b1;
         e.aluctl  = exp_alu(fn);
         e.illegal = !funct_ok(fn);
         drive(e, rbit(), rbit(), 1'b1);
         if (funct_ok(fn)) begin
            e          = mk(4'd8);
            e.regwrite = 1'b1;
            e.regdst   = 1'b1;
            drive(e, rbit(), rbit(), 1'b1);
         end
      end else if (op == OP_BEQ) begin
         zf        = (zsel == 2) ? rbit() : 1'(zsel);
         e         = mk(4'd9);
         e.alusrca = 1'b1;
         e.aluctl  = 3'b110;
         e.pcsrc   = 2'b01;
         e.pcen    = zf;
         drive(e, rbit(), zf, 1'b1);
      end else if (op == OP_ADDI) begin
         e         = mk(4'd10);
         e.alusrca = 1'b1;
         e.alusrcb = 2'b10;
         e.aluctl  = 3'b010;
         drive(e, rbit(), rbit(), 1'b1);
         e          = mk(4'd11);
         e.regwrite = 1'b1;
         drive(e, rbit(), rbit(), 1'b1);
      end else if (op == OP_J) begin
         e       = mk(4'd12);
         e.pcsrc = 2'b10;
         e.pcen  = 1'b1;
         drive(e, rbit(), rbit(), 1'b1);
      end
   endtask

   initial begin
      logic [5:0] op;
      logic [5:0] fn;
      int         r;
      rst_n         = 1'b0;
      bus.opcode    = 6'b000000;
      bus.funct     = 6'b000000;
      bus.Zero_flag = 1'b0;
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      drive(mk(4'd0), 1'b0, 1'b0, 1'b1);

      // Directed cases.
      run_instr(OP_LW,   6'b000000, 0, 0, 2, 1'b0);
      run_instr(OP_R,    6'b100010, 0, 0, 2, 1'b0);
      run_instr(OP_R,    6'b000111, 0, 0, 2, 1'b0);
      run_instr(OP_BEQ,  6'b000000, 0, 0, 1, 1'b0);
      run_instr(OP_BEQ,  6'b000000, 0, 0, 0, 1'b0);
      run_instr(OP_SW,   6'b000000, 0, 3, 2, 1'b0);
      run_instr(OP_ADDI, 6'b000000, TB_MAX, 0, 2, 1'b0);
      run_instr(OP_SW,   6'b000000, 0, TB_MAX, 2, 1'b0);
      run_instr(OP_LW,   6'b000000, 0, TB_MAX, 2, 1'b0);
      run_instr(OP_LW,   6'b000000, 1, 2, 2, 1'b1);
      run_instr(6'b111111, 6'b000000, 0, 0, 2, 1'b0);
      run_instr(OP_J,    6'b000000, 0, 0, 2, 1'b0);

      // Randomized instruction stream.
      for (int n = 0; n < 300; n++) begin
         r = int'($urandom_range(0, 7));
         case (r)
            0:       op = OP_LW;
            1:       op = OP_SW;
            2:       op = OP_R;
            3:       op = OP_BEQ;
            4:       op = OP_ADDI;
            5:       op = OP_J;
            6:       op = 6'b111111;
            default: op = 6'($urandom);
         endcase
         r = int'($urandom_range(0, 7));
         case (r)
            0:       fn = 6'b100000;
            1:       fn = 6'b100010;
            2:       fn = 6'b100100;
            3:       fn = 6'b100101;
            4:       fn = 6'b101010;
            default: fn = 6'($urandom);
         endcase
         run_instr(op, fn, -1, -1, 2, ($urandom_range(0, 19) == 0));
      end

      repeat (2) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
